// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and types for the instruction-fetch prefetch queue.
// Holds the bus widths, enable levels and the queue entry layout.
package if_prefetch_queue_pkg;

  localparam int   INST_ADDR_W = 32;    // InstAddrBus
  localparam int   INST_W      = 32;    // InstBus
  localparam logic CHIP_ENABLE = 1'b1;  // ChipEnable
  localparam logic RST_ENABLE  = 1'b1;  // RstEnable
  localparam int   IFQ_DEPTH   = 4;     // IfqDepth
  localparam int   IFQ_PTR_W   = $clog2(IFQ_DEPTH);  // IfqPtrBus

  // One queue slot: the fetch address packed above the instruction word.
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_mem.sv
// DEPTH x 64-bit entry storage for the prefetch queue:
// one synchronous write port, one combinational read port.
module ifq_mem
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifq_entry_t    rdata
);

  ifq_entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Prefetch queue between the IF stage and decode: buffers {pc, inst} pairs,
// stalls fetch when full, and drops everything on a branch/exception flush.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_ce,
  input  logic [INST_ADDR_W-1:0]   fetch_pc,
  input  logic [INST_W-1:0]        fetch_inst,
  output logic                     fetch_stall,
  output logic                     id_valid,
  output logic [INST_ADDR_W-1:0]   id_pc,
  output logic [INST_W-1:0]        id_inst,
  input  logic                     id_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  ifq_entry_t       wr_entry, rd_entry;

  // Full/empty come from the occupancy count; head == tail is ambiguous.
  assign fetch_stall = (count_q == CNT_W'(DEPTH));
  assign id_valid    = (count_q != '0);
  assign count       = count_q;

  assign push = (fetch_ce == CHIP_ENABLE) && !fetch_stall && !flush;
  assign pop  = id_valid && id_ready && !flush;

  assign wr_entry = '{pc: fetch_pc, inst: fetch_inst};

  ifq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata (wr_entry),
    .raddr (head_q),
    .rdata (rd_entry)
  );

  // An empty queue presents a NOP rather than a stale slot.
  assign id_pc   = id_valid ? rd_entry.pc   : '0;
  assign id_inst = id_valid ? rd_entry.inst : '0;

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
